// File: rtl/hyperbus_ctrl.sv
// hyperbus_ctrl: HyperBus CA/latency/data/CS# sequencer toward a word-per-clock PHY
module hyperbus_ctrl #(
  parameter int LATENCY     = 6,
  parameter int CSHI_CYCLES = 2,
  parameter int RD_TIMEOUT  = 64
) (
  input  logic        hbus_clk,
  input  logic        hbus_rst,
  input  logic [31:0] hbus_adr_i,
  input  logic [15:0] hbus_dat_i,
  output logic [15:0] hbus_dat_o,
  input  logic        hbus_rrq,
  input  logic        hbus_wrq,
  output logic        hbus_ready,
  output logic        hbus_valid,
  output logic        hbus_busy,
  output logic        hbus_err,
  output logic        phy_cs_n,
  output logic [15:0] phy_dq_o,
  output logic        phy_dq_oe,
  output logic [1:0]  phy_rwds_o,
  output logic        phy_rwds_oe,
  input  logic        phy_rwds_i,
  input  logic [15:0] phy_rdata,
  input  logic        phy_rvalid
);
  localparam int CW = $clog2(2 * LATENCY + CSHI_CYCLES + 4) + 1;
  localparam int TW = $clog2(RD_TIMEOUT + 1) + 1;
  typedef enum logic [2:0] {IDLE, CA, LAT, WDATA, RDATA, CSHI} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, lat;
  logic [TW-1:0] tcnt;
  logic [31:0] adr;
  logic [15:0] wdat;
  logic [47:0] ca;
  logic rd, dbl, wpend, tmo;
  assign ca = {rd, 1'b0, 1'b1, adr[31:3], 13'd0, adr[2:0]};
  assign lat = dbl ? CW'(2 * LATENCY) : CW'(LATENCY);
  assign tmo = state == RDATA && hbus_rrq && !phy_rvalid && tcnt == TW'(RD_TIMEOUT - 1);
  assign hbus_ready = state == WDATA && hbus_wrq;
  assign phy_cs_n = state == IDLE || state == CSHI;
  assign phy_rwds_oe = state == WDATA && wpend;
  assign phy_dq_oe = state == CA || phy_rwds_oe;
  assign phy_rwds_o = 2'b00;
  assign phy_dq_o = state == CA ? (cnt == '0 ? ca[47:32] : cnt == CW'(1) ? ca[31:16] : ca[15:0]) :
                    phy_rwds_oe ? wdat : '0;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = (hbus_rrq || hbus_wrq) ? CA : IDLE;
      CA:      state_n = cnt == CW'(2) ? LAT : CA;
      LAT:     state_n = cnt == lat - CW'(1) ? (rd ? RDATA : WDATA) : LAT;
      WDATA:   state_n = hbus_wrq ? WDATA : CSHI;
      RDATA:   state_n = (!hbus_rrq || tmo) ? CSHI : RDATA;
      CSHI:    state_n = cnt == CW'(CSHI_CYCLES - 1) ? IDLE : CSHI;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge hbus_clk or posedge hbus_rst)
    if (hbus_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tcnt       <= '0;
      adr        <= '0;
      rd         <= 1'b0;
      dbl        <= 1'b0;
      wpend      <= 1'b0;
      wdat       <= '0;
      hbus_dat_o <= '0;
      hbus_valid <= 1'b0;
      hbus_busy  <= 1'b0;
      hbus_err   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= state_n != state ? '0 : (&cnt ? cnt : cnt + 1'b1);
      tcnt       <= (state != RDATA || phy_rvalid) ? '0 : (&tcnt ? tcnt : tcnt + 1'b1);
      if (state == IDLE && (hbus_rrq || hbus_wrq)) begin
        adr <= hbus_adr_i;
        rd  <= hbus_rrq;
      end
      if (state == CA && cnt == CW'(1)) dbl <= phy_rwds_i;
      wpend      <= hbus_ready;
      if (hbus_ready) wdat <= hbus_dat_i;
      if (state == RDATA && phy_rvalid) hbus_dat_o <= phy_rdata;
      hbus_valid <= state == RDATA && state_n == RDATA && phy_rvalid;
      hbus_busy  <= state_n != IDLE;
      hbus_err   <= tmo;
    end
endmodule

// File: tb/tb_hyperbus_ctrl.sv
// tb_hyperbus_ctrl: table-driven, directed and randomized checks of hyperbus_ctrl against a transaction-level model
module tb_hyperbus_ctrl;
  localparam int LATENCY = 6, CSHI_CYCLES = 2, RD_TIMEOUT = 64;
  typedef struct {
    bit rd;
    bit wr;
    logic [31:0] adr;
    bit dl;
    int n;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [47:0] ca;
  } vec_t;
  logic hbus_clk = 0;
  logic hbus_rst = 1;
  logic [31:0] hbus_adr_i = '0;
  logic [15:0] hbus_dat_i = '0;
  logic [15:0] phy_rdata = '0;
  logic hbus_rrq = 0, hbus_wrq = 0, phy_rwds_i = 0, phy_rvalid = 0;
  logic [15:0] hbus_dat_o, phy_dq_o;
  logic hbus_ready, hbus_valid, hbus_busy, hbus_err, phy_cs_n, phy_dq_oe, phy_rwds_oe;
  logic [1:0] phy_rwds_o;
  int tests = 0, fails = 0, hi_run = 0;
  logic [15:0] dbuf [16];
  hyperbus_ctrl #(.LATENCY(LATENCY), .CSHI_CYCLES(CSHI_CYCLES), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .hbus_clk(hbus_clk), .hbus_rst(hbus_rst), .hbus_adr_i(hbus_adr_i), .hbus_dat_i(hbus_dat_i),
    .hbus_dat_o(hbus_dat_o), .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq), .hbus_ready(hbus_ready),
    .hbus_valid(hbus_valid), .hbus_busy(hbus_busy), .hbus_err(hbus_err), .phy_cs_n(phy_cs_n),
    .phy_dq_o(phy_dq_o), .phy_dq_oe(phy_dq_oe), .phy_rwds_o(phy_rwds_o), .phy_rwds_oe(phy_rwds_oe),
    .phy_rwds_i(phy_rwds_i), .phy_rdata(phy_rdata), .phy_rvalid(phy_rvalid)
  );
  always #5 hbus_clk = ~hbus_clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  function automatic logic [47:0] ca_model(input bit rd, input logic [31:0] a);
    return (48'(rd) << 47) | (48'd1 << 45) | (48'(a >> 3) << 16) | 48'(a % 8);
  endfunction
  task automatic fill(input int seed_unused);
    for (int k = 0; k < 16; k++) dbuf[k] = 16'($urandom + 32'(seed_unused));
  endtask
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input bit dl, input int n,
                     input bit phy_on, input bit chk_gap, input logic [47:0] xca, input string nm);
    int c = -1, o, lw, lowc = 0, hic = 0, acc = 0, nv = 0, drop = -1, gap = -1, errc = -1, nerr = 0, j = 0;
    bit done = 0, oe_bad = 0, busy_bad = 0, rw_bad = 0;
    logic [15:0] ca_obs [3];
    int sq[$], rdy[$], wo[$], vo[$], xo[$];
    logic [15:0] wd[$], vd[$], xd[$];
    lw = dl ? 2 * LATENCY : LATENCY;
    if (rd && phy_on) begin
      o = 3 + lw;
      sq.push_back(o - 1);
      for (int i = 0; i < n + 1; i++) begin
        sq.push_back(o);
        o += 1 + int'($urandom_range(0, 2));
      end
    end
    hbus_adr_i = a;
    for (int t = 0; t < 400 && !done; t++) begin
      @(posedge hbus_clk); #1;
      o = c < 0 ? 0 : c + 1;
      if (rd) begin
        hbus_rrq = nv < n && nerr == 0;
        hbus_wrq = wr && hbus_rrq;
        if (!hbus_rrq && drop < 0 && c >= 0) drop = o;
      end else hbus_wrq = acc < n;
      hbus_dat_i = acc < n ? dbuf[acc] : 16'($urandom);
      phy_rwds_i = o == 1 ? dl : !dl;
      phy_rvalid = c >= 0 && sq.size() > 0 && sq[0] == o;
      phy_rdata = 16'($urandom);
      if (phy_rvalid) begin
        void'(sq.pop_front());
        phy_rdata = j == 0 ? 16'hDEAD : dbuf[j - 1];
        if (o >= 3 + lw && hbus_rrq) begin
          xo.push_back(o + 1);
          xd.push_back(phy_rdata);
        end
        j++;
      end
      @(negedge hbus_clk);
      if (c >= 0) c++;
      else if (!phy_cs_n) begin
        c = 0;
        gap = hi_run;
      end
      hi_run = phy_cs_n ? hi_run + 1 : 0;
      if (phy_rwds_o !== 2'b00) rw_bad = 1;
      if (phy_cs_n && (phy_dq_oe || phy_rwds_oe)) oe_bad = 1;
      if (c >= 0) begin
        if (c < 3) begin
          ca_obs[c] = phy_dq_o;
          if (!phy_dq_oe) oe_bad = 1;
        end
        if (!phy_cs_n) lowc++;
        else if (hbus_busy) hic++;
        else done = 1;
        if (!phy_cs_n && !hbus_busy) busy_bad = 1;
        if (c >= 3 && phy_dq_oe) begin
          wo.push_back(c);
          wd.push_back(phy_dq_o);
        end
        if (c >= 3 && phy_rwds_oe !== phy_dq_oe) rw_bad = 1;
      end
      if (hbus_ready) begin
        rdy.push_back(c);
        acc++;
      end
      if (hbus_valid) begin
        vo.push_back(c);
        vd.push_back(hbus_dat_o);
        nv++;
      end
      if (hbus_err) begin
        errc = c;
        nerr++;
      end
    end
    chk({nm, " completed"}, done, 1);
    for (int i = 0; i < 3; i++) chk($sformatf("%s ca%0d", nm, i), ca_obs[i], 16'(xca >> (32 - 16 * i)));
    chk({nm, " oe"}, oe_bad, 0);
    chk({nm, " rwds"}, rw_bad, 0);
    chk({nm, " busy"}, busy_bad, 0);
    chk({nm, " cshi"}, hic, CSHI_CYCLES);
    if (chk_gap) chk({nm, " cs_gap_ok"}, gap >= CSHI_CYCLES, 1);
    chk({nm, " nvalid"}, vo.size(), xo.size());
    for (int i = 0; i < vo.size() && i < xo.size(); i++) begin
      chk($sformatf("%s vcyc%0d", nm, i), vo[i], xo[i]);
      chk($sformatf("%s vdat%0d", nm, i), vd[i], xd[i]);
    end
    if (rd) begin
      chk({nm, " nready"}, rdy.size(), 0);
      chk({nm, " nwords"}, wd.size(), 0);
      if (phy_on) begin
        chk({nm, " nerr"}, nerr, 0);
        chk({nm, " cs_low"}, lowc, drop + 1);
      end else begin
        chk({nm, " nerr"}, nerr, 1);
        chk({nm, " err_cyc"}, errc, 3 + lw + RD_TIMEOUT);
        chk({nm, " cs_low"}, lowc, 3 + lw + RD_TIMEOUT);
      end
    end else begin
      chk({nm, " nready"}, rdy.size(), n);
      chk({nm, " rdy0"}, rdy.size() > 0 ? rdy[0] : -1, 3 + lw);
      chk({nm, " nwords"}, wd.size(), n);
      for (int i = 0; i < wd.size() && i < n; i++) begin
        chk($sformatf("%s wcyc%0d", nm, i), wo[i], 3 + lw + 1 + i);
        chk($sformatf("%s wdat%0d", nm, i), wd[i], dbuf[i]);
      end
      chk({nm, " cs_low"}, lowc, 3 + lw + n + 1);
      chk({nm, " nerr"}, nerr, 0);
    end
  endtask
  initial begin
    vec_t vt [6];
    bit rd, wr, dl, seen;
    logic [31:0] a;
    int n;
    vt[0] = '{1'b0, 1'b1, 32'h10, 1'b0, 2, 16'hBEEF, 16'hCAFE, 48'h2000_0002_0000};
    vt[1] = '{1'b1, 1'b0, 32'h10, 1'b1, 2, 16'h1234, 16'h5678, 48'hA000_0002_0000};
    vt[2] = '{1'b1, 1'b1, 32'h7, 1'b0, 1, 16'h0F0F, 16'hF0F0, 48'hA000_0000_0007};
    vt[3] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 3, 16'hFFFF, 16'h0000, 48'h3FFF_FFFF_0007};
    vt[4] = '{1'b1, 1'b0, 32'h1234_5678, 1'b0, 4, 16'hA5A5, 16'h5A5A, 48'hA246_8ACF_0000};
    vt[5] = '{1'b0, 1'b1, 32'h8, 1'b0, 1, 16'h8001, 16'h0000, 48'h2000_0001_0000};
    #12;
    chk("reset ctl", {phy_cs_n, phy_dq_oe, phy_rwds_oe, hbus_ready, hbus_valid, hbus_busy, hbus_err}, 7'b1000000);
    chk("reset dq", phy_dq_o, 0);
    chk("reset dat", hbus_dat_o, 0);
    chk("reset rwds", phy_rwds_o, 0);
    @(posedge hbus_clk); #1 hbus_rst = 0;
    for (int i = 0; i < 6; i++) begin
      fill(i);
      dbuf[0] = vt[i].d0;
      dbuf[1] = vt[i].d1;
      txn(vt[i].rd, vt[i].wr, vt[i].adr, vt[i].dl, vt[i].n, 1, i > 0, vt[i].ca, $sformatf("vec%0d", i));
    end
    txn(1, 0, 32'h100, 0, 1, 0, 1, ca_model(1, 32'h100), "timeout");
    fill(0);
    txn(0, 1, 32'h20, 0, 2, 1, 1, ca_model(0, 32'h20), "b2b_a");
    fill(1);
    txn(0, 1, 32'h28, 1, 2, 1, 1, ca_model(0, 32'h28), "b2b_b");
    for (int i = 0; i < 20; i++) begin
      rd = 1'($urandom);
      wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      a = $urandom;
      dl = 1'($urandom);
      n = int'($urandom_range(1, 6));
      fill(i);
      txn(rd, wr, a, dl, n, 1, 1, ca_model(rd, a), $sformatf("rnd%0d", i));
    end
    hbus_adr_i = 32'h40;
    @(posedge hbus_clk); #1;
    hbus_wrq = 1;
    hbus_dat_i = 16'h5555;
    seen = 0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge hbus_clk);
      seen = hbus_ready;
    end
    chk("rst_mid reach_wdata", seen, 1);
    @(posedge hbus_clk); #1 hbus_rst = 1;
    #1;
    chk("rst_mid ctl", {phy_cs_n, phy_dq_oe, phy_rwds_oe, hbus_ready, hbus_busy}, 5'b10000);
    hbus_wrq = 0;
    @(posedge hbus_clk); #1 hbus_rst = 0;
    fill(7);
    txn(0, 1, 32'h40, 0, 2, 1, 0, ca_model(0, 32'h40), "post_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
